// File: rtl/gru_matvec_scheduler_pkg.sv
// Shared definitions for the GRU matrix-vector scheduler: FSM encoding,
// saturation limits and the widths derived from the tiling parameters.
package gru_matvec_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_ACC   = 3'd2;
  localparam state_t S_OUT   = 3'd3;
  localparam state_t S_FIN   = 3'd4;

  // Widths never collapse to zero, so single-tile configurations still elaborate.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int tile_count(input int rows, input int cols, input int h, input int x);
    return (rows / h) * (cols / x);
  endfunction

  function automatic int addr_width(input int rows, input int cols, input int h, input int x);
    return safe_clog2(tile_count(rows, cols, h, x));
  endfunction

  function automatic int grp_width(input int rows, input int h);
    return safe_clog2(rows / h);
  endfunction

  // Weights and activations are unsigned fixed point with half the bits fractional.
  function automatic int frac_bits(input int dw);
    return dw / 2;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/gru_matvec_scheduler_mult_n_bit2.sv
// Tile multiplier: each of H lanes is the fixed-point dot product of one weight
// row (X elements, lane h element j at [(h*X+j)*DW +: DW]) with the X-element slice.
module mult_n_bit2
  import gru_matvec_scheduler_pkg::*;
#(
  parameter int X          = 2,
  parameter int H          = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic [X*H*DATA_WIDTH-1:0] i_w,
  input  logic [X*DATA_WIDTH-1:0]   i_x,
  output logic [H*DATA_WIDTH-1:0]   o_lanes
);

  localparam int FRAC = frac_bits(DATA_WIDTH);
  localparam int PW   = DATA_WIDTH + FRAC;

  genvar gi;
  generate
    for (gi = 0; gi < H; gi++) begin : g_lane
      // Only bits [PW-1:FRAC] survive, so the sum is kept modulo 2^PW.
      logic [PW-1:0] w_sum;
      always_comb begin
        w_sum = '0;
        for (int j = 0; j < X; j++) begin
          w_sum = w_sum + PW'(i_w[(gi*X+j)*DATA_WIDTH +: DATA_WIDTH]) *
                          PW'(i_x[j*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
      assign o_lanes[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >> FRAC);
    end
  endgenerate

endmodule

// File: rtl/gru_matvec_scheduler.sv
// Tiled matrix-vector scheduler: fetches one weight tile every two cycles,
// accumulates per-row sums with saturation and hands out one row group at a time.
module gru_matvec_scheduler
  import gru_matvec_scheduler_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int X          = 2,
  parameter int H          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 12,
  localparam int ADDR_W    = addr_width(ROWS, COLS, H, X),
  localparam int GRP_W     = grp_width(ROWS, H)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [COLS*DATA_WIDTH-1:0]   x_vec,
  output logic                         w_rd,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic [X*H*DATA_WIDTH-1:0]    w_data,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [H*DATA_WIDTH-1:0]      y_data,
  output logic [GRP_W-1:0]             y_grp,
  output logic                         busy,
  output logic                         done
);

  localparam int NCOL = COLS / X;
  localparam int NROW = ROWS / H;
  localparam int CW   = safe_clog2(NCOL);
  localparam logic [CW-1:0]    COL_LAST = CW'(NCOL - 1);
  localparam logic [GRP_W-1:0] ROW_LAST = GRP_W'(NROW - 1);
  localparam logic signed [ACC_WIDTH:0]   ACC_HI = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0]   ACC_LO = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] OUT_HI = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] OUT_LO = ACC_WIDTH'(sat_min(DATA_WIDTH));

  state_t                      r_state;
  logic [CW-1:0]               r_col_grp;
  logic [GRP_W-1:0]            r_row_grp;
  logic [COLS*DATA_WIDTH-1:0]  r_x;
  logic signed [ACC_WIDTH-1:0] r_acc [H];
  logic signed [ACC_WIDTH-1:0] w_acc_add [H];
  logic [H*DATA_WIDTH-1:0]     w_lanes;
  logic [H*DATA_WIDTH-1:0]     w_y_sat;
  logic [X*DATA_WIDTH-1:0]     w_x_slice;

  assign w_x_slice = r_x[r_col_grp*X*DATA_WIDTH +: X*DATA_WIDTH];

  mult_n_bit2 #(.X(X), .H(H), .DATA_WIDTH(DATA_WIDTH)) u_mult (
    .i_w     (w_data),
    .i_x     (w_x_slice),
    .o_lanes (w_lanes)
  );

  genvar gi;
  generate
    for (gi = 0; gi < H; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0]     w_lane;
      logic signed [ACC_WIDTH:0] w_sum;
      assign w_lane = w_lanes[gi*DATA_WIDTH +: DATA_WIDTH];
      // One guard bit makes overflow visible before clamping.
      assign w_sum = {r_acc[gi][ACC_WIDTH-1], r_acc[gi]} +
                     {{(ACC_WIDTH+1-DATA_WIDTH){w_lane[DATA_WIDTH-1]}}, w_lane};
      assign w_acc_add[gi] = (w_sum > ACC_HI) ? ACC_HI[ACC_WIDTH-1:0] :
                             (w_sum < ACC_LO) ? ACC_LO[ACC_WIDTH-1:0] :
                                                w_sum[ACC_WIDTH-1:0];
      assign w_y_sat[gi*DATA_WIDTH +: DATA_WIDTH] =
          (r_acc[gi] > OUT_HI) ? OUT_HI[DATA_WIDTH-1:0] :
          (r_acc[gi] < OUT_LO) ? OUT_LO[DATA_WIDTH-1:0] :
                                 r_acc[gi][DATA_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_col_grp <= '0;
      r_row_grp <= '0;
      r_x       <= '0;
      for (int i = 0; i < H; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x       <= x_vec;
          r_col_grp <= '0;
          r_row_grp <= '0;
          for (int i = 0; i < H; i++) r_acc[i] <= '0;
          r_state   <= S_FETCH;
        end
        S_FETCH: r_state <= S_ACC;
        S_ACC: begin
          for (int i = 0; i < H; i++) r_acc[i] <= w_acc_add[i];
          if (r_col_grp != COL_LAST) begin
            r_col_grp <= r_col_grp + 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_state   <= S_OUT;
          end
        end
        S_OUT: if (y_ready) begin
          if (r_row_grp != ROW_LAST) begin
            for (int i = 0; i < H; i++) r_acc[i] <= '0;
            r_col_grp <= '0;
            r_row_grp <= r_row_grp + 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_state   <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd    = (r_state == S_FETCH);
  assign w_addr  = ADDR_W'(r_row_grp) * ADDR_W'(NCOL) + ADDR_W'(r_col_grp);
  assign y_valid = (r_state == S_OUT);
  assign y_data  = y_valid ? w_y_sat : '0;
  assign y_grp   = r_row_grp;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_FIN);

endmodule

// File: tb/tb_gru_matvec_scheduler.sv
// Randomised bench for gru_matvec_scheduler with a dot-product reference model
// and literal anchors for the zero, nominal, saturation and backpressure cases.
module tb_gru_matvec_scheduler;

  localparam int ROWS = 4, COLS = 4, X = 2, H = 2, DW = 8, AW = 12;
  localparam int NCOL = COLS / X;
  localparam int NROW = ROWS / H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x_vec = '0;
  logic        w_rd;
  logic [1:0]  w_addr;
  logic [31:0] w_data = '0;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [15:0] y_data;
  logic [0:0]  y_grp;
  logic        busy;
  logic        done;

  logic [31:0] mem [NROW*NCOL];
  logic [15:0] exp_y [NROW];
  logic [15:0] last_y0;
  int          cur_grp = 0;
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (w_rd) w_data <= mem[w_addr];

  gru_matvec_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .X(X), .H(H), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x_vec(x_vec),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_grp(y_grp),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  // Row h of group g: sum over column groups of the truncated fixed-point dot product.
  function automatic logic [15:0] model_grp(input logic [31:0] xv, input int g);
    logic [15:0] r;
    logic [31:0] tile;
    int acc, s, lane, wv, xe;
    r = '0;
    for (int h = 0; h < H; h++) begin
      acc = 0;
      for (int c = 0; c < NCOL; c++) begin
        tile = mem[g*NCOL + c];
        s = 0;
        for (int j = 0; j < X; j++) begin
          wv = int'(tile[(h*X+j)*DW +: DW]);
          xe = int'(xv[(c*X+j)*DW +: DW]);
          s += wv * xe;
        end
        lane = (s >> 4) & 255;
        if (lane > 127) lane -= 256;
        acc = clamp(acc + lane, -2048, 2047);
      end
      r[h*DW +: DW] = 8'(clamp(acc, -128, 127));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst && y_valid) begin
      if (cur_grp >= NROW) begin
        chk("extra_group", 64'(cur_grp), 64'(NROW - 1));
      end else begin
        chk("y_grp", 64'(y_grp), 64'(cur_grp));
        chk("y_data", 64'(y_data), 64'(exp_y[cur_grp]));
        chk("w_rd_in_out", 64'(w_rd), 64'd0);
        if (cur_grp == 0) last_y0 = y_data;
        if (y_ready) cur_grp++;
      end
    end
  end

  task automatic run_job(input logic [31:0] xv, input int bp, input bit pulse, input string tag);
    int cyc, stall;
    for (int g = 0; g < NROW; g++) exp_y[g] = model_grp(xv, g);
    cur_grp = 0;
    stall = bp;
    mon_en = 1'b1;
    @(posedge clk); #1;
    x_vec = xv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_vec = $urandom;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = pulse && (cyc % 3 == 0) && (cyc < 10);
      if (y_valid && stall > 0) begin
        y_ready = 1'b0;
        stall--;
      end else begin
        y_ready = 1'b1;
      end
    end
    start = 1'b0;
    y_ready = 1'b1;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(11 + bp));
    chk({tag, "_groups"}, 64'(cur_grp), 64'(NROW));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    mon_en = 1'b0;
    $display("[TB] job %s x=%h bp=%0d pulse=%0d exp0=%h exp1=%h cycles=%0d",
             tag, xv, bp, pulse, exp_y[0], exp_y[1], cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_rd"}, 64'(w_rd), 64'd0);
    chk({tag, "_w_addr"}, 64'(w_addr), 64'd0);
    chk({tag, "_y_valid"}, 64'(y_valid), 64'd0);
    chk({tag, "_y_data"}, 64'(y_data), 64'd0);
    chk({tag, "_y_grp"}, 64'(y_grp), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xv;
    int cyc;
    for (int i = 0; i < NROW*NCOL; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    run_job(32'h02020202, 0, 1'b0, "zero");
    chk("zero_y0", 64'(last_y0), 64'h0000);

    for (int i = 0; i < NROW*NCOL; i++) mem[i] = 32'h80808080;
    chk("model_nominal", 64'(model_grp(32'h02020202, 0)), 64'h4040);
    run_job(32'h02020202, 0, 1'b0, "nominal");
    chk("nominal_y0", 64'(last_y0), 64'h4040);

    chk("model_sat", 64'(model_grp(32'h08080808, 1)), 64'h8080);
    run_job(32'h08080808, 0, 1'b0, "saturate");
    chk("saturate_y0", 64'(last_y0), 64'h8080);

    run_job(32'h02020202, 5, 1'b1, "backpressure");
    chk("backpressure_y0", 64'(last_y0), 64'h4040);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NROW*NCOL; i++) mem[i] = $urandom;
      run_job($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end

    // Reset during the accumulate phase of group 1, then a fresh job.
    for (int i = 0; i < NROW*NCOL; i++) mem[i] = $urandom;
    xv = $urandom;
    for (int g = 0; g < NROW; g++) exp_y[g] = model_grp(xv, g);
    cur_grp = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    x_vec = xv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 6) begin
        chk("abort_fetch_rd", 64'(w_rd), 64'd1);
        chk("abort_fetch_addr", 64'(w_addr), 64'd2);
      end
    end
    chk("abort_group0_seen", 64'(cur_grp), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_reset_outputs("abort");
    mon_en = 1'b0;
    $display("[TB] job abort x=%h reset asserted in cycle 7", xv);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NROW*NCOL; i++) mem[i] = $urandom;
    run_job($urandom, 0, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
